// File: rtl/tbu_lifo_out.sv
// ---------------------------------------------------------------------------
// tbu_lifo_out
//   Output reversal stage for the Viterbi traceback unit. The tbu writes each
//   traceback block newest-first. This block stores every block in one of two
//   ping-pong bit banks and replays it oldest-first on a valid/ready stream.
//   One bank can fill while the other drains.
//
// Optional build macro:
//   TBU_LIFO_LAST_EN : adds output d_last, which marks the final bit of a block.
//
// Parameters:
//   DEPTH : maximum bits per traceback block (bank size), 2..256
//   AW    : pointer/count width, derived from DEPTH (do not override)
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-low reset
//   enable    in   global decoder enable; writes are accepted only when high
//   wr_en     in   tbu output-valid
//   d_in      in   decoded bit from the tbu (newest-first)
//   out_ready in   downstream ready
//   ovf_clr   in   synchronous clear of the sticky overflow flag
//   d_out     out  decoded bit, time-ordered (oldest first)
//   d_valid   out  d_out valid
//   ovf       out  sticky overflow flag (a bit was dropped)
//   d_last    out  final bit of a block (TBU_LIFO_LAST_EN only)
// ---------------------------------------------------------------------------
module tbu_lifo_out #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic wr_en,
    input  logic d_in,
    input  logic out_ready,
    input  logic ovf_clr,
    output logic d_out,
    output logic d_valid,
    output logic ovf
`ifdef TBU_LIFO_LAST_EN
    ,
    output logic d_last
`endif
);

    localparam int IW = AW - 1;   // bank address width

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      full_q, full_d;
    logic            wbank_q, wbank_d;
    logic            rbank_q, rbank_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW-1:0]   cnt_q [2];
    logic [AW-1:0]   cnt_d [2];
    logic            ovf_q, ovf_d;
    logic            active_q, active_d;
    logic            hold_q, hold_d;

    logic [DEPTH-1:0] mem_q [2];

    logic            active;
    logic            wr_ok;
    logic            wr_drop;
    logic            close_a;
    logic            close_b;
    logic [IW-1:0]   rd_addr;
    logic            rd_bit;
    logic            rd_valid;
    logic            rd_last;

    assign active   = enable & wr_en;
    // Full flags are sampled before the edge: a bank freed by the reader on
    // this same edge still rejects the write.
    assign wr_ok    = active & ~full_q[wbank_q];
    assign wr_drop  = active &  full_q[wbank_q];
    // Bank filled to capacity by this write.
    assign close_a  = wr_ok && (wptr_q == AW'(DEPTH - 1));
    // End of a tbu burst. enable=0 pauses the write side rather than ending
    // the block, so the falling edge is only judged while enable is high.
    assign close_b  = enable && active_q && !wr_en && (wptr_q != '0);

    // Highest written address holds the oldest bit, so replay counts down.
    assign rd_addr  = IW'(cnt_q[rbank_q] - rptr_q - AW'(1));
    assign rd_bit   = mem_q[rbank_q][rd_addr];
    assign rd_valid = (state_q == ST_READ);
    assign rd_last  = (rptr_q == (cnt_q[rbank_q] - AW'(1)));

    always_comb begin
        state_d  = state_q;
        full_d   = full_q;
        wbank_d  = wbank_q;
        rbank_d  = rbank_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        hold_d   = hold_q;
        active_d = enable ? active : active_q;

        // Write side and block close
        if (wr_ok) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (close_a) begin
            full_d[wbank_q] = 1'b1;
            cnt_d[wbank_q]  = AW'(DEPTH);
            wbank_d         = ~wbank_q;
            wptr_d          = '0;
        end else if (close_b) begin
            full_d[wbank_q] = 1'b1;
            cnt_d[wbank_q]  = wptr_q;
            wbank_d         = ~wbank_q;
            wptr_d          = '0;
        end

        // Sticky overflow; a new drop wins over a same-edge clear.
        if (ovf_clr) ovf_d = 1'b0;
        if (wr_drop) ovf_d = 1'b1;

        // Read FSM
        case (state_q)
            ST_IDLE: begin
                if (full_q[rbank_q]) begin
                    rptr_d  = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                hold_d = rd_bit;   // keeps d_out stable once the block ends
                if (out_ready) begin
                    if (rd_last) begin
                        full_d[rbank_q] = 1'b0;
                        rbank_d         = ~rbank_q;
                        state_d         = ST_IDLE;
                    end else begin
                        rptr_d = rptr_q + AW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            full_q   <= '0;
            wbank_q  <= 1'b0;
            rbank_q  <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            ovf_q    <= 1'b0;
            active_q <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            full_q   <= full_d;
            wbank_q  <= wbank_d;
            rbank_q  <= rbank_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            ovf_q    <= ovf_d;
            active_q <= active_d;
            hold_q   <= hold_d;
        end
    end

    // Bank storage: contents need no reset, only the full/count state does.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wbank_q][wptr_q[IW-1:0]] <= d_in;
        end
    end

    assign d_valid = rd_valid;
    assign d_out   = rd_valid ? rd_bit : hold_q;
    assign ovf     = ovf_q;

`ifdef TBU_LIFO_LAST_EN
    assign d_last  = rd_valid && rd_last;
`endif

endmodule

// File: tb/tb_tbu_lifo_out.sv
module tb_tbu_lifo_out;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic wr_en = 1'b0;
    logic d_in = 1'b0;
    logic out_ready = 1'b0;
    logic ovf_clr = 1'b0;
    logic d_out;
    logic d_valid;
    logic ovf;
`ifdef TBU_LIFO_LAST_EN
    logic d_last;
`endif

    int n_pass  = 0;
    int n_total = 0;

    tbu_lifo_out #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .wr_en     (wr_en),
        .d_in      (d_in),
        .out_ready (out_ready),
        .ovf_clr   (ovf_clr),
        .d_out     (d_out),
        .d_valid   (d_valid),
        .ovf       (ovf)
`ifdef TBU_LIFO_LAST_EN
        ,
        .d_last    (d_last)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write n bits b[0], b[1], ... in consecutive cycles, then drop wr_en.
    task automatic wr_bits(input logic [15:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            enable = 1'b1;
            wr_en  = 1'b1;
            d_in   = b[i];
            tick();
        end
        wr_en = 1'b0;
        d_in  = 1'b0;
    endtask

    // Accept everything offered for a number of cycles; rec[i] = i-th bit.
    task automatic collect(input int cycles, output logic [31:0] rec, output int n);
        rec = '0;
        n   = 0;
        out_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            if (d_valid === 1'b1 && n < 32) begin
                rec[n] = d_out;
                n++;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #3;
        n_total++; if (d_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", d_valid); else n_pass++;
        n_total++; if (d_out !== 1'b0) $display("FAIL reset_dout: got %b want 0", d_out); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
        tick();
        tick();
        rst = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [4:0] exp_o;
        exp_o = 5'b10110;   // outputs 0,1,1,0,1 (bit 0 first)
        out_ready = 1'b1;
        wr_bits(16'b01101, 5);   // writes 1,0,1,1,0
        n_total++; if (d_valid !== 1'b0) $display("FAIL basic_valid_w4: got %b want 0", d_valid); else n_pass++;
        tick();   // edge E: block closes
        n_total++; if (d_valid !== 1'b0) $display("FAIL basic_valid_e: got %b want 0", d_valid); else n_pass++;
        tick();   // edge E+1: READ
        for (int k = 0; k < 5; k++) begin
            n_total++; if (d_valid !== 1'b1) $display("FAIL basic_valid[%0d]: got %b want 1", k, d_valid); else n_pass++;
            n_total++; if (d_out !== exp_o[k]) $display("FAIL basic_dout[%0d]: got %b want %b", k, d_out, exp_o[k]); else n_pass++;
`ifdef TBU_LIFO_LAST_EN
            n_total++; if (d_last !== (k == 4)) $display("FAIL basic_last[%0d]: got %b want %b", k, d_last, (k == 4)); else n_pass++;
`endif
            tick();
        end
        n_total++; if (d_valid !== 1'b0) $display("FAIL basic_valid_end: got %b want 0", d_valid); else n_pass++;
        n_total++; if (d_out !== 1'b1) $display("FAIL basic_dout_hold: got %b want 1", d_out); else n_pass++;
        $display("test_basic done");
    endtask

    task automatic test_auto_close();
        logic [10:0] b;
        logic [10:0] exp_o;
        logic [31:0] rec;
        int idx [11];
        int n;
        b     = 11'b110_1000_1011;   // b[0..10] = 1,1,0,1,0,0,0,1,0,1,1
        exp_o = 11'b011_1101_0001;   // 1,0,0,0,1,0,1,1 then 1,1,0
        rec = '0;
        n = 0;
        out_ready = 1'b1;
        enable = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (d_valid === 1'b1 && n < 11) begin
                rec[n] = d_out;
                idx[n] = c;
                n++;
            end
            wr_en = (c < 11);
            d_in  = (c < 11) ? b[c] : 1'b0;
            tick();
        end
        n_total++; if (n != 11) $display("FAIL auto_count: got %0d want 11", n); else n_pass++;
        n_total++; if (rec[10:0] !== exp_o) $display("FAIL auto_bits: got %b want %b", rec[10:0], exp_o); else n_pass++;
        n_total++; if (n == 11 && idx[8] - idx[7] - 1 != 1) $display("FAIL auto_bubble: got %0d want 1", idx[8] - idx[7] - 1); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL auto_ovf: got %b want 0", ovf); else n_pass++;
        $display("test_auto_close done");
    endtask

    task automatic test_backpressure();
        logic [8:0] pat;
        logic [5:0] exp_o;
        logic [5:0] rec;
        logic prev;
        int n;
        int w;
        pat   = 9'b111101001;   // out_ready 1,0,0,1,0,1,1,1,1
        exp_o = 6'b011010;      // outputs 0,1,0,1,1,0
        rec = '0;
        n = 0;
        out_ready = 1'b0;
        wr_bits(16'b010110, 6);  // writes 0,1,1,0,1,0
        w = 0;
        while (d_valid !== 1'b1 && w < 10) begin
            tick();
            w++;
        end
        n_total++; if (d_valid !== 1'b1) $display("FAIL bp_timeout: got %b want 1", d_valid); else n_pass++;
        for (int k = 0; k < 9; k++) begin
            out_ready = pat[k];
            prev = d_out;
            if (pat[k] && d_valid === 1'b1 && n < 6) begin
                rec[n] = d_out;
                n++;
            end
            tick();
            if (!pat[k]) begin
                n_total++; if (d_out !== prev || d_valid !== 1'b1) $display("FAIL bp_stall[%0d]: got %b/%b want %b/1", k, d_out, d_valid, prev); else n_pass++;
            end
        end
        out_ready = 1'b1;
        n_total++; if (n != 6) $display("FAIL bp_count: got %0d want 6", n); else n_pass++;
        n_total++; if (rec !== exp_o) $display("FAIL bp_bits: got %b want %b", rec, exp_o); else n_pass++;
        n_total++; if (d_valid !== 1'b0) $display("FAIL bp_valid_end: got %b want 0", d_valid); else n_pass++;
        $display("test_backpressure done");
    endtask

    task automatic test_overflow();
        logic [31:0] rec;
        int n;
        out_ready = 1'b0;
        wr_bits(16'b1001, 4);   // 1,0,0,1 -> bank 0
        tick();
        wr_bits(16'b1011, 4);   // 1,1,0,1 -> bank 1
        tick();
        wr_bits(16'b1010, 4);   // 0,1,0,1 -> dropped
        tick();
        tick();
        n_total++; if (ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", ovf); else n_pass++;
        n_total++; if (d_valid !== 1'b1) $display("FAIL ovf_valid: got %b want 1", d_valid); else n_pass++;
        n_total++; if (d_out !== 1'b1) $display("FAIL ovf_first: got %b want 1", d_out); else n_pass++;
        collect(30, rec, n);
        n_total++; if (n != 8) $display("FAIL ovf_count: got %0d want 8", n); else n_pass++;
        n_total++; if (rec[7:0] !== 8'b11011001) $display("FAIL ovf_bits: got %b want %b", rec[7:0], 8'b11011001); else n_pass++;
        n_total++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf); else n_pass++;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_total++; if (ovf !== 1'b0) $display("FAIL ovf_clr: got %b want 0", ovf); else n_pass++;
        $display("test_overflow done");
    endtask

    task automatic test_enable();
        logic [31:0] rec;
        int n;
        out_ready = 1'b1;
        enable = 1'b1; wr_en = 1'b1;
        d_in = 1'b1; tick();
        d_in = 1'b1; tick();
        enable = 1'b0; d_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++; if (d_valid !== 1'b0) $display("FAIL en_noclose[%0d]: got %b want 0", k, d_valid); else n_pass++;
        end
        enable = 1'b1;
        d_in = 1'b0; tick();
        d_in = 1'b1; tick();
        wr_en = 1'b0; d_in = 1'b0;
        collect(15, rec, n);
        n_total++; if (n != 4) $display("FAIL en_count: got %0d want 4", n); else n_pass++;
        n_total++; if (rec[3:0] !== 4'b1101) $display("FAIL en_bits: got %b want %b", rec[3:0], 4'b1101); else n_pass++;
        $display("test_enable done");
    endtask

    task automatic test_midreset();
        logic [31:0] rec;
        int n;
        out_ready = 1'b0;
        wr_bits(16'b10, 2);     // 0,1 -> first output 1
        tick();
        wr_bits(16'b11, 2);
        tick();
        wr_bits(16'b1, 1);      // both banks full: dropped
        tick();
        n_total++; if (ovf !== 1'b1 || d_valid !== 1'b1 || d_out !== 1'b1)
            $display("FAIL mr_pre: got ovf=%b valid=%b dout=%b want 1/1/1", ovf, d_valid, d_out); else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++; if (d_valid !== 1'b0) $display("FAIL mr_valid: got %b want 0", d_valid); else n_pass++;
        n_total++; if (d_out !== 1'b0) $display("FAIL mr_dout: got %b want 0", d_out); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL mr_ovf: got %b want 0", ovf); else n_pass++;
        tick();
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        wr_bits(16'b110, 3);    // 0,1,1
        collect(20, rec, n);
        n_total++; if (n != 3) $display("FAIL mr_count: got %0d want 3", n); else n_pass++;
        n_total++; if (rec[2:0] !== 3'b011) $display("FAIL mr_bits: got %b want %b", rec[2:0], 3'b011); else n_pass++;
        $display("test_midreset done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_auto_close();
        test_backpressure();
        test_overflow();
        test_enable();
        test_midreset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
